// File: rtl/rtc_bus_responder_pkg.sv
// Shared definitions for the RTC bus responder: register map, index encoding, FSM states.
// Address decode and reset-value helpers are used by the top and by system benches.
package rtc_bus_responder_pkg;

  localparam logic [7:0] ADDR_SEG     = 8'h21;
  localparam logic [7:0] ADDR_MIN     = 8'h22;
  localparam logic [7:0] ADDR_HORA    = 8'h23;
  localparam logic [7:0] ADDR_DIA     = 8'h24;
  localparam logic [7:0] ADDR_MES     = 8'h25;
  localparam logic [7:0] ADDR_JAHR    = 8'h26;
  localparam logic [7:0] ADDR_DOW     = 8'h27;
  localparam logic [7:0] ADDR_SEG_T   = 8'h41;
  localparam logic [7:0] ADDR_MIN_T   = 8'h42;
  localparam logic [7:0] ADDR_HORA_T  = 8'h43;
  localparam logic [7:0] ADDR_CONTROL = 8'hF0;

  localparam int NUM_REGS = 11;

  localparam logic [3:0] IDX_SEG    = 4'd0;
  localparam logic [3:0] IDX_MIN    = 4'd1;
  localparam logic [3:0] IDX_HORA   = 4'd2;
  localparam logic [3:0] IDX_DIA    = 4'd3;
  localparam logic [3:0] IDX_MES    = 4'd4;
  localparam logic [3:0] IDX_JAHR   = 4'd5;
  localparam logic [3:0] IDX_DOW    = 4'd6;
  localparam logic [3:0] IDX_SEG_T  = 4'd7;
  localparam logic [3:0] IDX_MIN_T  = 4'd8;
  localparam logic [3:0] IDX_HORA_T = 4'd9;
  localparam logic [3:0] IDX_CTRL   = 4'd10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DWR,
    ST_DRD
  } state_t;

  typedef struct packed {
    logic       hit;
    logic [3:0] idx;
  } reg_sel_t;

  function automatic reg_sel_t decode_addr(input logic [7:0] a);
    reg_sel_t s;
    s.hit = 1'b1;
    s.idx = IDX_SEG;
    case (a)
      ADDR_SEG:     s.idx = IDX_SEG;
      ADDR_MIN:     s.idx = IDX_MIN;
      ADDR_HORA:    s.idx = IDX_HORA;
      ADDR_DIA:     s.idx = IDX_DIA;
      ADDR_MES:     s.idx = IDX_MES;
      ADDR_JAHR:    s.idx = IDX_JAHR;
      ADDR_DOW:     s.idx = IDX_DOW;
      ADDR_SEG_T:   s.idx = IDX_SEG_T;
      ADDR_MIN_T:   s.idx = IDX_MIN_T;
      ADDR_HORA_T:  s.idx = IDX_HORA_T;
      ADDR_CONTROL: s.idx = IDX_CTRL;
      default:      s.hit = 1'b0;
    endcase
    return s;
  endfunction

  // Day and month count from 1, everything else from 0.
  function automatic logic [7:0] reset_value(input logic [3:0] idx);
    return (idx == IDX_DIA || idx == IDX_MES) ? 8'h01 : 8'h00;
  endfunction

endpackage

// File: rtl/rtc_bus_responder_if.sv
// Multiplexed A/D bus between escritor_lector_rtc_2 (master) and the RTC responder (slave).
// dato_oe flags when the responder is driving dato.
interface rtc_bus_responder_if;
  logic       AD;
  logic       CS;
  logic       WR;
  logic       RD;
  wire  [7:0] dato;
  logic       dato_oe;

  modport master (output AD, CS, WR, RD, inout dato, input dato_oe);
  modport slave  (input AD, CS, WR, RD, inout dato, output dato_oe);
endinterface

// File: rtl/rtc_bus_responder_bcd_time_counter.sv
// One BCD time field with wrap-around increment, borrow decrement and a priority load port.
// Only built with RTC_TIMEKEEP_EN defined.
`ifdef RTC_TIMEKEEP_EN
module rtc_bcd_time_counter #(
  parameter logic [7:0] MAX_BCD = 8'h59
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       inc,
  input  logic       dec,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic [7:0] q,
  output logic       at_max,
  output logic       at_zero
);
  logic [7:0] q_inc, q_dec;

  assign at_max  = (q == MAX_BCD);
  assign at_zero = (q == 8'h00);

  always_comb begin
    q_inc = q + 8'h01;
    if (q >= MAX_BCD)        q_inc = 8'h00;
    else if (q[3:0] == 4'h9) q_inc = {q[7:4] + 4'h1, 4'h0};
    q_dec = q - 8'h01;
    if (q == 8'h00)          q_dec = MAX_BCD;
    else if (q[3:0] == 4'h0) q_dec = {q[7:4] - 4'h1, 4'h9};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    q <= 8'h00;
    else if (load) q <= load_val;
    else if (inc)  q <= q_inc;
    else if (dec)  q <= q_dec;
  end
endmodule
`endif

// File: rtl/rtc_bus_responder.sv
// RTC responder on the multiplexed A/D bus: strobe sync, command FSM, BCD register file, read tristate.
// Define RTC_TIMEKEEP_EN to add the 1 s prescaler and the BCD clock/timer counters.
// state    | meaning
// ST_IDLE  | waiting for a command while CS is low
// ST_ADDR  | address phase, addr_q loads on WR rise
// ST_DWR   | data write, mapped register loads on WR rise
// ST_DRD   | data read, dato driven while RD and CS stay low
module rtc_bus_responder
  import rtc_bus_responder_pkg::*;
#(
  parameter int SYNC_STAGES = 2
`ifdef RTC_TIMEKEEP_EN
  , parameter int TICK_DIV = 100_000_000
`endif
) (
  input  logic               clk,
  input  logic               reset,
  rtc_bus_responder_if.slave bus,
  output logic [7:0]         addr_q,
  output logic               wr_done,
  output logic               bus_error
);
  logic [SYNC_STAGES-1:0] ad_sync, cs_sync, wr_sync, rd_sync;
  logic       ad_s, cs_s, wr_s, rd_s, wr_prev, wr_rise;
  logic       illegal, err_lock;
  state_t     state, state_n;
  logic       addr_ld, reg_we, we_hit, oe;
  reg_sel_t   sel;
  logic [7:0] regs [NUM_REGS];
  logic [7:0] view [NUM_REGS];
  logic [7:0] rd_data;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ad_sync <= '0;
      cs_sync <= '1;
      wr_sync <= '1;
      rd_sync <= '1;
      wr_prev <= 1'b1;
    end else begin
      ad_sync <= {ad_sync[SYNC_STAGES-2:0], bus.AD};
      cs_sync <= {cs_sync[SYNC_STAGES-2:0], bus.CS};
      wr_sync <= {wr_sync[SYNC_STAGES-2:0], bus.WR};
      rd_sync <= {rd_sync[SYNC_STAGES-2:0], bus.RD};
      wr_prev <= wr_s;
    end
  end

  assign ad_s    = ad_sync[SYNC_STAGES-1];
  assign cs_s    = cs_sync[SYNC_STAGES-1];
  assign wr_s    = wr_sync[SYNC_STAGES-1];
  assign rd_s    = rd_sync[SYNC_STAGES-1];
  assign wr_rise = wr_s & ~wr_prev;
  assign illegal = ~cs_s & ~rd_s & (~wr_s | ~ad_s);

  always_comb begin
    state_n = state;
    addr_ld = 1'b0;
    reg_we  = 1'b0;
    if (illegal) begin
      state_n = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!cs_s && !err_lock) begin
            if (!ad_s && !wr_s)     state_n = ST_ADDR;
            else if (ad_s && !wr_s) state_n = ST_DWR;
            else if (ad_s && !rd_s) state_n = ST_DRD;
          end
        end
        ST_ADDR: begin
          if (cs_s) state_n = ST_IDLE;
          else if (wr_rise) begin
            addr_ld = 1'b1;
            state_n = ST_IDLE;
          end
        end
        ST_DWR: begin
          if (cs_s) state_n = ST_IDLE;
          else if (wr_rise) begin
            reg_we  = 1'b1;
            state_n = ST_IDLE;
          end
        end
        ST_DRD: if (cs_s || rd_s) state_n = ST_IDLE;
        default: state_n = ST_IDLE;
      endcase
    end
  end

  assign sel    = decode_addr(addr_q);
  assign we_hit = reg_we & sel.hit;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      addr_q    <= 8'h00;
      wr_done   <= 1'b0;
      bus_error <= 1'b0;
      err_lock  <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= reset_value(4'(i));
    end else begin
      state     <= state_n;
      wr_done   <= we_hit;
      bus_error <= illegal & ~err_lock;
      // Lock out new commands until both strobes have returned high.
      if (illegal)          err_lock <= 1'b1;
      else if (wr_s & rd_s) err_lock <= 1'b0;
      if (addr_ld) addr_q <= bus.dato;
      if (we_hit)  regs[sel.idx] <= bus.dato;
    end
  end

`ifdef RTC_TIMEKEEP_EN
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_TOP = PW'(TICK_DIV - 1);
  logic [PW-1:0] presc;
  logic       hold, tick, timer_nz;
  logic [7:0] seg_q, min_q, hora_q, seg_t_q, min_t_q, hora_t_q;
  logic       seg_max, min_max, seg_t_zero, min_t_zero;

  assign hold     = regs[IDX_CTRL][0];
  assign tick     = ~hold & (presc == '0);
  assign timer_nz = |{seg_t_q, min_t_q, hora_t_q};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)   presc <= PRESC_TOP;
    else if (!hold) presc <= (presc == '0) ? PRESC_TOP : presc - 1'b1;
  end

  rtc_bcd_time_counter #(.MAX_BCD(8'h59)) u_seg (.clk, .reset, .inc(tick), .dec(1'b0),
    .load(we_hit && sel.idx == IDX_SEG), .load_val(bus.dato), .q(seg_q), .at_max(seg_max), .at_zero());
  rtc_bcd_time_counter #(.MAX_BCD(8'h59)) u_min (.clk, .reset, .inc(tick & seg_max), .dec(1'b0),
    .load(we_hit && sel.idx == IDX_MIN), .load_val(bus.dato), .q(min_q), .at_max(min_max), .at_zero());
  rtc_bcd_time_counter #(.MAX_BCD(8'h23)) u_hora (.clk, .reset, .inc(tick & seg_max & min_max),
    .dec(1'b0), .load(we_hit && sel.idx == IDX_HORA), .load_val(bus.dato), .q(hora_q), .at_max(),
    .at_zero());
  rtc_bcd_time_counter #(.MAX_BCD(8'h59)) u_seg_t (.clk, .reset, .inc(1'b0), .dec(tick & timer_nz),
    .load(we_hit && sel.idx == IDX_SEG_T), .load_val(bus.dato), .q(seg_t_q), .at_max(),
    .at_zero(seg_t_zero));
  rtc_bcd_time_counter #(.MAX_BCD(8'h59)) u_min_t (.clk, .reset, .inc(1'b0),
    .dec(tick & timer_nz & seg_t_zero), .load(we_hit && sel.idx == IDX_MIN_T), .load_val(bus.dato),
    .q(min_t_q), .at_max(), .at_zero(min_t_zero));
  rtc_bcd_time_counter #(.MAX_BCD(8'h23)) u_hora_t (.clk, .reset, .inc(1'b0),
    .dec(tick & timer_nz & seg_t_zero & min_t_zero), .load(we_hit && sel.idx == IDX_HORA_T),
    .load_val(bus.dato), .q(hora_t_q), .at_max(), .at_zero());
`endif

  always_comb begin
    view = regs;
`ifdef RTC_TIMEKEEP_EN
    view[IDX_SEG]    = seg_q;
    view[IDX_MIN]    = min_q;
    view[IDX_HORA]   = hora_q;
    view[IDX_SEG_T]  = seg_t_q;
    view[IDX_MIN_T]  = min_t_q;
    view[IDX_HORA_T] = hora_t_q;
`endif
  end

  assign rd_data     = sel.hit ? view[sel.idx] : 8'h00;
  assign oe          = (state == ST_DRD);
  assign bus.dato_oe = oe;
  assign bus.dato    = oe ? rd_data : 8'hzz;
endmodule
